lagarto_csr_access_unit: RTL and testbench
==========================================

Name: lagarto_csr_access_unit

Overview:
Pipeline-side initiator of the CSR command interface served by the exception handler. Accepts one decoded Zicsr instruction (CSRRW/RS/RC and immediate forms), holds it until it is the oldest instruction, then drives the CSR read/write command sequence. Returns the old CSR value to writeback and requests a pipeline flush after any CSR write. Sits between the issue stage and the exception handler.

Parameters:
MXLEN, 64, CSR data width; matches riscv_privileged_pkg.
RESPONSE_TIMEOUT, 255, cycles to wait for read data before aborting; minimum 1.

Ports:
clock_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
req_valid_i  in  1  CSR instruction offered
req_ready_o  out  1  unit can accept; high only in IDLE
req_funct3_i  in  3  Zicsr funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
req_address_i  in  12  CSR address
req_operand_i  in  MXLEN  rs1 value, or zero-extended uimm for I-forms
req_rs1_is_zero_i  in  1  rs1 index or uimm field is 0
req_rd_i  in  5  destination register index
instruction_is_oldest_i  in  1  held instruction is at commit head
kill_i  in  1  pipeline flush from the exception handler
csr_command_o  out  2  00 NONE, 01 READ, 10 WRITE, 11 reserved/never driven
csr_address_o  out  12  address for current command
csr_write_data_o  out  MXLEN  data for a WRITE command
csr_read_data_i  in  MXLEN  read data
csr_read_data_valid_i  in  1  read data valid strobe
result_valid_o  out  1  result available
result_ready_i  in  1  writeback accepts result
result_data_o  out  MXLEN  old CSR value; 0 if read was skipped or timed out
result_rd_o  out  5  destination register
flush_request_o  out  1  one-cycle pulse after a WRITE command
illegal_instruction_o  out  1  one-cycle pulse; write to read-only CSR
timeout_error_o  out  1  one-cycle pulse; read response timed out

Behaviour:
- Reset: state IDLE. All outputs 0 except req_ready_o=1. csr_command_o=NONE. Timeout counter=0. Reset mid-operation discards the held instruction; no command is issued in the reset cycle.
- Accept on req_valid_i && req_ready_o. All request fields are registered. Read is skipped when funct3 is RW/RWI and rd=0. Write is skipped when funct3 is RS/RC/RSI/RCI and req_rs1_is_zero_i=1.
- States: IDLE -> WAIT_COMMIT -> (READ_REQ -> READ_WAIT)? -> (WRITE_REQ)? -> RESPOND -> IDLE.
- WAIT_COMMIT: hold until instruction_is_oldest_i=1. kill_i here returns to IDLE and produces no output. kill_i is ignored in all later states; the access is non-speculative once issued.
- Illegal check in WAIT_COMMIT on commit: if a write is needed and address[11:10]=11, pulse illegal_instruction_o and return to IDLE. No command is issued and no result is produced.
- READ_REQ: csr_command_o=READ for exactly 1 cycle, with csr_address_o valid.
- READ_WAIT: capture csr_read_data_i on the first cycle that csr_read_data_valid_i=1. A valid asserted in the READ_REQ cycle is also accepted, giving minimum latency 0. The counter increments each waiting cycle. On reaching RESPONSE_TIMEOUT: pulse timeout_error_o, set old value=0, skip the write, go to RESPOND.
- Write data: RW = operand; RS = old | operand; RC = old & ~operand. If the read was skipped, old=0 for this computation.
- WRITE_REQ: csr_command_o=WRITE for 1 cycle with address and data. The write takes effect in that cycle; there is no acknowledge. flush_request_o pulses in the following cycle, concurrent with entry to RESPOND.
- RESPOND: result_valid_o=1 with stable data and rd until result_ready_i. Transfer goes to IDLE; req_ready_o rises the next cycle. The unit never holds more than one instruction.
- csr_address_o and csr_write_data_o are 0 whenever csr_command_o=NONE.
- csr_read_data_valid_i outside READ_REQ/READ_WAIT is ignored.

Decomposition:
- riscv_privileged_pkg: csr_command_t enum (NONE/READ/WRITE), csr_funct3_t enum, CSR_ADDR_WIDTH=12, read-only address-field constant 2'b11.
- Local state_t enum stays in the module.
- One natural sub-module: lagarto_csr_alu, combinational RW/RS/RC write-data computation.

Test Plan:
- CSRRS addr 0x300, operand 0x8, rd=5, read returns 0x1800 after 2 cycles -> READ pulse, then WRITE data 0x1808, flush pulse, result 0x1800 rd=5.
- CSRRW rd=0 operand 0xDEAD -> no READ, single WRITE 0xDEAD, result_data 0.
- CSRRC rs1=x0 addr 0xC00 -> READ only, no WRITE, no flush, no illegal. Same with rs1!=0 -> illegal pulse, no command.
- kill_i while in WAIT_COMMIT -> IDLE, no command, no result. kill_i during READ_WAIT -> ignored, normal completion.
- Read never valid, RESPONSE_TIMEOUT=4 -> timeout pulse after 4 cycles, result 0, no WRITE.
- result_ready_i low for 3 cycles -> result held stable, req_ready_o low. Reset asserted in READ_WAIT -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/riscv_privileged_pkg.sv
// Shared CSR command/funct3 encodings for the pipeline-side CSR initiator
// and the exception handler that serves it.
package riscv_privileged_pkg;

    localparam int         CSR_MXLEN      = 64;
    localparam int         CSR_ADDR_WIDTH = 12;
    localparam logic [1:0] CSR_RO_FIELD   = 2'b11;

    typedef enum logic [1:0] {
        CSR_CMD_NONE  = 2'b00,
        CSR_CMD_READ  = 2'b01,
        CSR_CMD_WRITE = 2'b10
    } csr_command_t;

    typedef enum logic [2:0] {
        CSR_RW  = 3'b001,
        CSR_RS  = 3'b010,
        CSR_RC  = 3'b011,
        CSR_RWI = 3'b101,
        CSR_RSI = 3'b110,
        CSR_RCI = 3'b111
    } csr_funct3_t;

    function automatic logic csr_is_swap(input logic [2:0] funct3);
        return (funct3 == CSR_RW) || (funct3 == CSR_RWI);
    endfunction

    function automatic logic csr_is_set(input logic [2:0] funct3);
        return (funct3 == CSR_RS) || (funct3 == CSR_RSI);
    endfunction

    function automatic logic csr_is_clear(input logic [2:0] funct3);
        return (funct3 == CSR_RC) || (funct3 == CSR_RCI);
    endfunction

endpackage

// File: rtl/lagarto_csr_alu.sv
// Combinational Zicsr write-data computation: swap, set-bits or clear-bits
// against the old CSR value.
module lagarto_csr_alu
    import riscv_privileged_pkg::*;
#(
    parameter int MXLEN = CSR_MXLEN
) (
    input  logic [2:0]       funct3,
    input  logic [MXLEN-1:0] old_value,
    input  logic [MXLEN-1:0] operand,
    output logic [MXLEN-1:0] write_data
);

    always_comb begin
        write_data = operand;
        if (csr_is_set(funct3)) begin
            write_data = old_value | operand;
        end else if (csr_is_clear(funct3)) begin
            write_data = old_value & ~operand;
        end
    end

endmodule

// File: rtl/lagarto_csr_access_unit.sv
// Holds one Zicsr instruction until commit, then sequences the CSR read/write
// commands toward the exception handler and returns the old value to writeback.
module lagarto_csr_access_unit
    import riscv_privileged_pkg::*;
#(
    parameter int MXLEN            = CSR_MXLEN,
    parameter int RESPONSE_TIMEOUT = 255
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [2:0]                req_funct3_i,
    input  logic [CSR_ADDR_WIDTH-1:0] req_address_i,
    input  logic [MXLEN-1:0]          req_operand_i,
    input  logic                      req_rs1_is_zero_i,
    input  logic [4:0]                req_rd_i,
    input  logic                      instruction_is_oldest_i,
    input  logic                      kill_i,
    output csr_command_t              csr_command_o,
    output logic [CSR_ADDR_WIDTH-1:0] csr_address_o,
    output logic [MXLEN-1:0]          csr_write_data_o,
    input  logic [MXLEN-1:0]          csr_read_data_i,
    input  logic                      csr_read_data_valid_i,
    output logic                      result_valid_o,
    input  logic                      result_ready_i,
    output logic [MXLEN-1:0]          result_data_o,
    output logic [4:0]                result_rd_o,
    output logic                      flush_request_o,
    output logic                      illegal_instruction_o,
    output logic                      timeout_error_o
);

    localparam int CNT_W = (RESPONSE_TIMEOUT < 2) ? 1 : $clog2(RESPONSE_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, WAIT_COMMIT, READ_REQ, READ_WAIT, WRITE_REQ, RESPOND
    } state_t;

    state_t                    state, state_next;
    logic [2:0]                funct3;
    logic [CSR_ADDR_WIDTH-1:0] address;
    logic [MXLEN-1:0]          operand;
    logic [MXLEN-1:0]          old_value;
    logic [MXLEN-1:0]          alu_data;
    logic [4:0]                rd;
    logic                      read_needed;
    logic                      write_needed;
    logic [CNT_W-1:0]          wait_count;
    logic                      flush_pulse;
    logic                      illegal_pulse;
    logic                      timeout_pulse;

    logic commit;
    logic illegal;
    logic read_fire;
    logic read_timeout;

    assign commit       = (state == WAIT_COMMIT) && instruction_is_oldest_i && !kill_i;
    assign illegal      = write_needed && (address[11:10] == CSR_RO_FIELD);
    assign read_fire    = ((state == READ_REQ) || (state == READ_WAIT)) && csr_read_data_valid_i;
    // The READ_REQ cycle does not count: the wait budget covers READ_WAIT cycles only.
    assign read_timeout = (state == READ_WAIT) && !csr_read_data_valid_i
                          && (wait_count == CNT_W'(RESPONSE_TIMEOUT - 1));

    lagarto_csr_alu #(.MXLEN(MXLEN)) u_alu (
        .funct3     (funct3),
        .old_value  (old_value),
        .operand    (operand),
        .write_data (alu_data)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state         <= IDLE;
            funct3        <= '0;
            address       <= '0;
            operand       <= '0;
            old_value     <= '0;
            rd            <= '0;
            read_needed   <= 1'b0;
            write_needed  <= 1'b0;
            wait_count    <= '0;
            flush_pulse   <= 1'b0;
            illegal_pulse <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= state_next;
            flush_pulse   <= (state == WRITE_REQ);
            illegal_pulse <= commit && illegal;
            timeout_pulse <= read_timeout;
            if (state == IDLE && req_valid_i) begin
                funct3       <= req_funct3_i;
                address      <= req_address_i;
                operand      <= req_operand_i;
                rd           <= req_rd_i;
                old_value    <= '0;
                read_needed  <= !(csr_is_swap(req_funct3_i) && req_rd_i == 5'd0);
                write_needed <= csr_is_swap(req_funct3_i) || !req_rs1_is_zero_i;
            end
            if (read_fire) begin
                old_value <= csr_read_data_i;
            end
            if (state == READ_REQ) begin
                wait_count <= '0;
            end else if (state == READ_WAIT) begin
                wait_count <= wait_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid_i) state_next = WAIT_COMMIT;
            end
            WAIT_COMMIT: begin
                if (kill_i) begin
                    state_next = IDLE;
                end else if (instruction_is_oldest_i) begin
                    if (illegal)           state_next = IDLE;
                    else if (read_needed)  state_next = READ_REQ;
                    else if (write_needed) state_next = WRITE_REQ;
                    else                   state_next = RESPOND;
                end
            end
            READ_REQ, READ_WAIT: begin
                if (csr_read_data_valid_i) begin
                    state_next = write_needed ? WRITE_REQ : RESPOND;
                end else if (state == READ_REQ) begin
                    state_next = READ_WAIT;
                end else if (read_timeout) begin
                    state_next = RESPOND;
                end
            end
            WRITE_REQ: state_next = RESPOND;
            RESPOND: begin
                if (result_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Gated by reset so a command in flight is never presented during the reset cycle.
    always_comb begin
        csr_command_o    = CSR_CMD_NONE;
        csr_address_o    = '0;
        csr_write_data_o = '0;
        if (!reset_i) begin
            if (state == READ_REQ) begin
                csr_command_o = CSR_CMD_READ;
                csr_address_o = address;
            end else if (state == WRITE_REQ) begin
                csr_command_o    = CSR_CMD_WRITE;
                csr_address_o    = address;
                csr_write_data_o = alu_data;
            end
        end
    end

    assign req_ready_o           = (state == IDLE);
    assign result_valid_o        = (state == RESPOND);
    assign result_data_o         = (state == RESPOND) ? old_value : '0;
    assign result_rd_o           = (state == RESPOND) ? rd : 5'd0;
    assign flush_request_o       = flush_pulse;
    assign illegal_instruction_o = illegal_pulse;
    assign timeout_error_o       = timeout_pulse;

endmodule

// File: tb/tb_lagarto_csr_access_unit.sv
// Bench for lagarto_csr_access_unit: directed vector table, randomized
// instructions against a reference model, and a reset-mid-read sequence.
module tb_lagarto_csr_access_unit;

    localparam int TMO = 4;

    logic        clock = 1'b0;
    logic        reset_i;
    logic        req_valid_i, req_ready_o;
    logic [2:0]  req_funct3_i;
    logic [11:0] req_address_i;
    logic [63:0] req_operand_i;
    logic        req_rs1_is_zero_i;
    logic [4:0]  req_rd_i;
    logic        instruction_is_oldest_i, kill_i;
    logic [1:0]  csr_command_o;
    logic [11:0] csr_address_o;
    logic [63:0] csr_write_data_o, csr_read_data_i;
    logic        csr_read_data_valid_i;
    logic        result_valid_o, result_ready_i;
    logic [63:0] result_data_o;
    logic [4:0]  result_rd_o;
    logic        flush_request_o, illegal_instruction_o, timeout_error_o;

    always #5 clock = ~clock;

    lagarto_csr_access_unit #(.MXLEN(64), .RESPONSE_TIMEOUT(TMO)) dut (
        .clock_i(clock), .reset_i(reset_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_funct3_i(req_funct3_i), .req_address_i(req_address_i),
        .req_operand_i(req_operand_i), .req_rs1_is_zero_i(req_rs1_is_zero_i),
        .req_rd_i(req_rd_i), .instruction_is_oldest_i(instruction_is_oldest_i),
        .kill_i(kill_i), .csr_command_o(csr_command_o),
        .csr_address_o(csr_address_o), .csr_write_data_o(csr_write_data_o),
        .csr_read_data_i(csr_read_data_i), .csr_read_data_valid_i(csr_read_data_valid_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_data_o(result_data_o), .result_rd_o(result_rd_o),
        .flush_request_o(flush_request_o), .illegal_instruction_o(illegal_instruction_o),
        .timeout_error_o(timeout_error_o)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [63:0] op;
        bit          rs1z;
        logic [4:0]  rd;
        int          lat, odly, rdly;
        bit          kw, kr;
        logic [63:0] preset;
    } stim_t;

    typedef struct {
        int          nrd, nwr, nill, ntmo, nres;
        logic [63:0] wd, res;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    int          vectors = 0;
    int          miscompares = 0;
    bit          spur = 1'b0;
    logic [63:0] mem [logic [11:0]];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] memget(input logic [11:0] a);
        if (mem.exists(a)) return mem[a];
        return 64'hA5A5_0000_0000_0000 ^ {52'd0, a};
    endfunction

    // Reference: outcome of one instruction from the Zicsr rules and the current CSR value.
    function automatic exp_t model(input stim_t s, input logic [63:0] cur);
        exp_t        e;
        bit          swap, do_rd, do_wr;
        logic [63:0] old;
        e = '{default: 0};
        swap  = (s.f3 == 3'b001) || (s.f3 == 3'b101);
        do_rd = !(swap && s.rd == 5'd0);
        do_wr = swap || !s.rs1z;
        if (s.kw) return e;
        if (do_wr && s.addr >= 12'hC00) begin
            e.nill = 1;
            return e;
        end
        e.nres = 1;
        if (do_rd && s.lat > TMO) begin
            e.nrd  = 1;
            e.ntmo = 1;
            return e;
        end
        old   = do_rd ? cur : 64'd0;
        e.nrd = do_rd ? 1 : 0;
        e.res = old;
        if (do_wr) begin
            e.nwr = 1;
            if (swap)                                  e.wd = s.op;
            else if (s.f3 == 3'b010 || s.f3 == 3'b110) e.wd = old | s.op;
            else                                       e.wd = old & ~s.op;
        end
        return e;
    endfunction

    function automatic vec_t mk(input logic [2:0] f3, input logic [11:0] a, input logic [63:0] op,
                                input bit rz, input logic [4:0] rd, input int lat, input int odly,
                                input int rdly, input bit kw, input bit kr, input logic [63:0] pre,
                                input int nrd, input int nwr, input int nill, input int ntmo,
                                input int nres, input logic [63:0] wd, input logic [63:0] res);
        vec_t v;
        v.s = '{f3: f3, addr: a, op: op, rs1z: rz, rd: rd, lat: lat, odly: odly, rdly: rdly,
                kw: kw, kr: kr, preset: pre};
        v.e = '{nrd: nrd, nwr: nwr, nill: nill, ntmo: ntmo, nres: nres, wd: wd, res: res};
        return v;
    endfunction

    task automatic run_vec(input stim_t s, input exp_t e, input string nm);
        int          cyc, rd_cnt, nrd, nwr, nill, ntmo, nres, perr, hold, limit;
        logic [63:0] wd, res_first;
        logic [11:0] raddr;
        logic [4:0]  rrd;
        bit          prev_wr, xfer, fin, got;
        nrd = 0; nwr = 0; nill = 0; ntmo = 0; nres = 0; perr = 0; hold = 0;
        wd = '0; res_first = '0; raddr = '0; rrd = '0;
        prev_wr = 0; xfer = 0; fin = 0; got = 0; rd_cnt = -1;
        @(negedge clock);
        chk({nm, ".ready_idle"}, req_ready_o, 1);
        req_valid_i = 1; req_funct3_i = s.f3; req_address_i = s.addr; req_operand_i = s.op;
        req_rs1_is_zero_i = s.rs1z; req_rd_i = s.rd;
        instruction_is_oldest_i = 0; kill_i = 0; result_ready_i = 0;
        limit = (e.nres == 0) ? s.odly + 6 : 80;
        cyc = 0;
        while (!fin && cyc < limit) begin
            @(negedge clock);
            // Scramble request fields: the unit must work from its registered copy.
            req_valid_i = 0; req_funct3_i = 3'($urandom); req_address_i = 12'($urandom);
            req_operand_i = {$urandom, $urandom}; req_rd_i = 5'($urandom);
            req_rs1_is_zero_i = 1'($urandom);
            result_ready_i = 0;
            if (csr_command_o == 2'b11) perr++;
            if (csr_command_o == 2'b00 && (csr_address_o != 0 || csr_write_data_o != 0)) perr++;
            if (flush_request_o != prev_wr) perr++;
            prev_wr = (csr_command_o == 2'b10);
            if (csr_command_o == 2'b01) begin
                nrd++; raddr = csr_address_o; rd_cnt = 0;
            end
            if (csr_command_o == 2'b10) begin
                nwr++; wd = csr_write_data_o; mem[csr_address_o] = csr_write_data_o;
                if (csr_address_o != s.addr) perr++;
            end
            if (illegal_instruction_o) nill++;
            if (timeout_error_o) begin
                ntmo++;
                if (!result_valid_o) perr++;
            end
            if (xfer) begin
                if (result_valid_o || !req_ready_o) perr++;
                fin = 1;
            end else if (result_valid_o) begin
                if (!got) begin
                    got = 1; res_first = result_data_o; rrd = result_rd_o;
                end else if (result_data_o != res_first || result_rd_o != rrd) begin
                    perr++;
                end
                if (req_ready_o) perr++;
                if (hold >= s.rdly) begin
                    result_ready_i = 1; xfer = 1; nres++;
                end else begin
                    hold++;
                end
            end else if (e.nres != 0 && req_ready_o) begin
                perr++;
            end
            csr_read_data_valid_i = 0; csr_read_data_i = {$urandom, $urandom};
            if (rd_cnt >= 0) begin
                if (rd_cnt == s.lat) begin
                    csr_read_data_valid_i = 1; csr_read_data_i = memget(raddr); rd_cnt = -1;
                end else begin
                    rd_cnt++;
                end
            end else if (spur) begin
                csr_read_data_valid_i = 1'($urandom);
            end
            instruction_is_oldest_i = !s.kw && (cyc >= s.odly);
            kill_i = (s.kw && cyc == s.odly) || (s.kr && rd_cnt >= 0);
            cyc++;
        end
        if (e.nres != 0) chk({nm, ".completed"}, fin, 1);
        instruction_is_oldest_i = 0; kill_i = 0; result_ready_i = 0; csr_read_data_valid_i = 0;
        chk({nm, ".reads"}, nrd, e.nrd);
        chk({nm, ".writes"}, nwr, e.nwr);
        chk({nm, ".illegal"}, nill, e.nill);
        chk({nm, ".timeout"}, ntmo, e.ntmo);
        chk({nm, ".results"}, nres, e.nres);
        chk({nm, ".protocol_errs"}, perr, 0);
        if (e.nrd != 0) chk({nm, ".read_addr"}, raddr, s.addr);
        if (e.nwr != 0) chk({nm, ".write_data"}, wd, e.wd);
        if (e.nres != 0) begin
            chk({nm, ".result_data"}, res_first, e.res);
            chk({nm, ".result_rd"}, rrd, s.rd);
        end
    endtask

    vec_t tbl[15];
    logic [2:0]  f3_set[6]   = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
    logic [11:0] addr_set[6] = '{12'h300, 12'h340, 12'h7C0, 12'hC00, 12'hF14, 12'h305};

    initial begin
        stim_t s;
        exp_t  e;
        int    n;
        tbl[0]  = mk(3'b010, 12'h300, 64'h8,    0, 5, 2,  1, 0, 0, 0, 64'h1800, 1, 1, 0, 0, 1, 64'h1808, 64'h1800);
        tbl[1]  = mk(3'b001, 12'h340, 64'hDEAD, 0, 0, 0,  0, 0, 0, 0, 64'h55,   0, 1, 0, 0, 1, 64'hDEAD, 64'h0);
        tbl[2]  = mk(3'b011, 12'hC00, 64'h0,    1, 3, 1,  0, 0, 0, 0, 64'hABC,  1, 0, 0, 0, 1, 64'h0,    64'hABC);
        tbl[3]  = mk(3'b011, 12'hC00, 64'h1,    0, 3, 1,  0, 0, 0, 0, 64'hABC,  0, 0, 1, 0, 0, 64'h0,    64'h0);
        tbl[4]  = mk(3'b010, 12'h305, 64'h1,    0, 2, 1,  2, 0, 1, 0, 64'h7,    0, 0, 0, 0, 0, 64'h0,    64'h0);
        tbl[5]  = mk(3'b010, 12'h305, 64'h10,   0, 2, 3,  0, 0, 0, 1, 64'h1,    1, 1, 0, 0, 1, 64'h11,   64'h1);
        tbl[6]  = mk(3'b010, 12'h341, 64'hF,    0, 4, 99, 0, 0, 0, 0, 64'h77,   1, 0, 0, 1, 1, 64'h0,    64'h0);
        tbl[7]  = mk(3'b011, 12'h300, 64'hF0,   0, 9, 1,  0, 3, 0, 0, 64'hFF,   1, 1, 0, 0, 1, 64'h0F,   64'hFF);
        tbl[8]  = mk(3'b101, 12'h300, 64'h1F,   0, 7, 0,  0, 0, 0, 0, 64'h123,  1, 1, 0, 0, 1, 64'h1F,   64'h123);
        tbl[9]  = mk(3'b111, 12'h300, 64'h3,    0, 1, 1,  0, 0, 0, 0, 64'h1808, 1, 1, 0, 0, 1, 64'h1808, 64'h1808);
        tbl[10] = mk(3'b010, 12'h300, 64'h100,  0, 6, 4,  0, 0, 0, 0, 64'h2,    1, 1, 0, 0, 1, 64'h102,  64'h2);
        tbl[11] = mk(3'b010, 12'h300, 64'h100,  0, 6, 5,  0, 0, 0, 0, 64'h2,    1, 0, 0, 1, 1, 64'h0,    64'h0);
        tbl[12] = mk(3'b110, 12'hC01, 64'h0,    1, 8, 2,  0, 0, 0, 0, 64'h99,   1, 0, 0, 0, 1, 64'h0,    64'h99);
        tbl[13] = mk(3'b001, 12'hC00, 64'h5,    0, 0, 0,  0, 0, 0, 0, 64'h0,    0, 0, 1, 0, 0, 64'h0,    64'h0);
        tbl[14] = mk(3'b101, 12'hC02, 64'h5,    0, 3, 0,  0, 0, 0, 0, 64'h0,    0, 0, 1, 0, 0, 64'h0,    64'h0);

        reset_i = 1; req_valid_i = 0; req_funct3_i = 0; req_address_i = 0; req_operand_i = 0;
        req_rs1_is_zero_i = 0; req_rd_i = 0; instruction_is_oldest_i = 0; kill_i = 0;
        csr_read_data_i = 0; csr_read_data_valid_i = 0; result_ready_i = 0;
        repeat (2) @(negedge clock);
        chk("reset.req_ready", req_ready_o, 1);
        chk("reset.outputs", {csr_command_o, csr_address_o, csr_write_data_o, result_valid_o,
                              flush_request_o, illegal_instruction_o, timeout_error_o}, 0);
        chk("reset.result", {result_data_o, result_rd_o}, 0);
        reset_i = 0;

        for (int i = 0; i < 15; i++) begin
            mem[tbl[i].s.addr] = tbl[i].s.preset;
            run_vec(tbl[i].s, tbl[i].e, $sformatf("vec%0d", i));
        end

        spur = 1;
        for (int i = 0; i < 40; i++) begin
            s.f3   = f3_set[$urandom_range(0, 5)];
            s.addr = ($urandom_range(0, 3) == 0) ? 12'($urandom) : addr_set[$urandom_range(0, 5)];
            s.rs1z = ($urandom_range(0, 3) == 0);
            if (s.rs1z)        s.op = 64'd0;
            else if (s.f3[2])  s.op = 64'($urandom_range(1, 31));
            else               s.op = {$urandom, $urandom};
            s.rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            s.lat  = ($urandom_range(0, 5) == 0) ? 99 : $urandom_range(0, TMO + 1);
            s.odly = $urandom_range(0, 3);
            s.rdly = $urandom_range(0, 3);
            s.kw   = ($urandom_range(0, 7) == 0);
            s.kr   = ($urandom_range(0, 3) == 0);
            s.preset = '0;
            e = model(s, memget(s.addr));
            run_vec(s, e, $sformatf("rnd%0d", i));
        end
        spur = 0;

        // Reset while waiting on read data drops the held instruction.
        @(negedge clock);
        req_valid_i = 1; req_funct3_i = 3'b010; req_address_i = 12'h300; req_operand_i = 64'h1;
        req_rs1_is_zero_i = 0; req_rd_i = 5'd5; instruction_is_oldest_i = 1;
        @(negedge clock);
        req_valid_i = 0;
        n = 0;
        while (csr_command_o != 2'b01 && n < 10) begin
            @(negedge clock);
            n++;
        end
        chk("rstseq.read_issued", csr_command_o, 2'b01);
        @(negedge clock);
        chk("rstseq.busy", req_ready_o, 0);
        reset_i = 1;
        @(negedge clock);
        chk("rstseq.req_ready", req_ready_o, 1);
        chk("rstseq.outputs", {csr_command_o, csr_address_o, csr_write_data_o, result_valid_o,
                               flush_request_o, illegal_instruction_o, timeout_error_o}, 0);
        reset_i = 0; instruction_is_oldest_i = 0;
        repeat (3) @(negedge clock);
        chk("rstseq.stays_idle", {req_ready_o, csr_command_o, result_valid_o}, {1'b1, 2'b00, 1'b0});
        mem[tbl[0].s.addr] = tbl[0].s.preset;
        run_vec(tbl[0].s, tbl[0].e, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
